// File: rtl/i2c_seq_ctrl.sv
// Sequences register reads/writes on an I2C master core: init prescale/enable, then per-request command/poll steps.
// Latency: depends on core TIP polling; one-cycle rsp_valid_o pulse per request. Backpressure: req_ready_o only in IDLE.
// Polling ends on TIP clear (checked for AL, then RxACK) or on timeout after 2^TO_W-1 busy samples.
module i2c_seq_ctrl #(
    parameter int          TO_W     = 16,
    parameter logic [15:0] PRESCALE = 16'h0063
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rnw_i,
    input  logic [6:0] req_dev_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_err_o,
    output logic [2:0] core_addr_o,
    output logic [7:0] core_wdata_o,
    output logic       core_we_o,
    output logic       core_re_o,
    input  logic [7:0] core_rdata_i
);

    typedef enum logic [3:0] {
        S_INIT0, S_INIT1, S_INIT2, S_IDLE, S_TXR, S_CR, S_POLL, S_WAIT,
        S_SMP, S_RD, S_RWAIT, S_RSMP, S_DONE
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic            rnw;
    logic [6:0]      dev;
    logic [7:0]      rg;
    logic [7:0]      wd;
    logic [1:0]      step;
    logic            stopping;
    logic [TO_W-1:0] cnt;
    logic [7:0]      tx_byte;
    logic [7:0]      cr_byte;
    logic [1:0]      last_step;

    // Step 2 of a read re-addresses the slave for the repeated START.
    always_comb begin
        tx_byte = {dev, 1'b0};
        cr_byte = 8'h90;
        case (step)
            2'd0: begin tx_byte = {dev, 1'b0};                  cr_byte = 8'h90; end
            2'd1: begin tx_byte = rg;                           cr_byte = 8'h10; end
            2'd2: begin tx_byte = rnw ? {dev, 1'b1} : wd;       cr_byte = rnw ? 8'h90 : 8'h50; end
            default: begin tx_byte = 8'h00;                     cr_byte = 8'h68; end
        endcase
        last_step = rnw ? 2'd3 : 2'd2;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_INIT0;
            req_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= 8'h00;
            rsp_err_o    <= 2'b00;
            core_addr_o  <= 3'd0;
            core_wdata_o <= 8'h00;
            core_we_o    <= 1'b0;
            core_re_o    <= 1'b0;
            rnw          <= 1'b0;
            dev          <= 7'h00;
            rg           <= 8'h00;
            wd           <= 8'h00;
            step         <= 2'd0;
            stopping     <= 1'b0;
            cnt          <= '0;
        end else begin
            core_we_o <= 1'b0;
            core_re_o <= 1'b0;
            case (state)
                S_INIT0: begin
                    core_we_o <= 1'b1; core_addr_o <= 3'd0; core_wdata_o <= PRESCALE[7:0];
                    state <= S_INIT1;
                end
                S_INIT1: begin
                    core_we_o <= 1'b1; core_addr_o <= 3'd1; core_wdata_o <= PRESCALE[15:8];
                    state <= S_INIT2;
                end
                S_INIT2: begin
                    core_we_o <= 1'b1; core_addr_o <= 3'd2; core_wdata_o <= 8'h80;
                    req_ready_o <= 1'b1;
                    state <= S_IDLE;
                end
                S_IDLE: begin
                    if (req_valid_i) begin
                        rnw <= req_rnw_i; dev <= req_dev_i; rg <= req_reg_i; wd <= req_wdata_i;
                        step <= 2'd0; stopping <= 1'b0; req_ready_o <= 1'b0;
                        state <= S_TXR;
                    end
                end
                S_TXR: begin
                    core_we_o <= 1'b1; core_addr_o <= 3'd3; core_wdata_o <= tx_byte;
                    state <= S_CR;
                end
                S_CR: begin
                    core_we_o <= 1'b1; core_addr_o <= 3'd4;
                    core_wdata_o <= stopping ? 8'h40 : cr_byte;
                    cnt <= '0;
                    state <= S_POLL;
                end
                S_POLL: begin
                    core_re_o <= 1'b1; core_addr_o <= 3'd4;
                    state <= S_WAIT;
                end
                S_WAIT: state <= S_SMP;
                S_SMP: begin
                    if (core_rdata_i[1]) begin
                        if (cnt == TO_LAST) begin
                            rsp_valid_o <= 1'b1; rsp_err_o <= stopping ? 2'b01 : 2'b11;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + TO_ONE;
                            core_re_o <= 1'b1; core_addr_o <= 3'd4;
                            state <= S_WAIT;
                        end
                    end else if (core_rdata_i[5] || stopping) begin
                        rsp_valid_o <= 1'b1; rsp_err_o <= stopping ? 2'b01 : 2'b10;
                        state <= S_DONE;
                    end else if (core_rdata_i[7] && !(rnw && step == 2'd3)) begin
                        stopping <= 1'b1;
                        state <= S_CR;
                    end else if (step == last_step) begin
                        if (rnw) begin
                            state <= S_RD;
                        end else begin
                            rsp_valid_o <= 1'b1; rsp_err_o <= 2'b00;
                            state <= S_DONE;
                        end
                    end else begin
                        step <= step + 2'd1;
                        state <= (rnw && step == 2'd2) ? S_CR : S_TXR;
                    end
                end
                S_RD: begin
                    core_re_o <= 1'b1; core_addr_o <= 3'd3;
                    state <= S_RWAIT;
                end
                S_RWAIT: state <= S_RSMP;
                S_RSMP: begin
                    rsp_valid_o <= 1'b1; rsp_err_o <= 2'b00; rsp_rdata_o <= core_rdata_i;
                    state <= S_DONE;
                end
                S_DONE: begin
                    rsp_valid_o <= 1'b0; rsp_rdata_o <= 8'h00; rsp_err_o <= 2'b00;
                    req_ready_o <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_INIT0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Scoreboard bench for i2c_seq_ctrl: expected core writes and responses are queued by stimulus, checked by a monitor.
module tb_i2c_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_rnw;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic [2:0] core_addr;
    logic [7:0] core_wdata;
    logic       core_we, core_re;
    logic [7:0] core_rdata = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] wq[$];
    logic [15:0] rq[$];

    int         tip_n   = 0;
    int         left    = 0;
    int         sr_reads = 0;
    logic [7:0] sr_end  = 8'h00;
    logic [7:0] rxr     = 8'h00;

    always #5 clk = ~clk;

    i2c_seq_ctrl #(.TO_W(4), .PRESCALE(16'h0063)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rnw_i(req_rnw),
        .req_dev_i(req_dev), .req_reg_i(req_reg), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .core_addr_o(core_addr), .core_wdata_o(core_wdata),
        .core_we_o(core_we), .core_re_o(core_re), .core_rdata_i(core_rdata)
    );

    // Core model: TIP stays set for tip_n SR reads after each CR write, then SR reads sr_end.
    always @(posedge clk) begin
        if (core_we && core_addr == 3'd4) left = tip_n;
        if (core_re) begin
            if (core_addr == 3'd4) begin
                sr_reads++;
                if (left > 0) begin
                    left--;
                    core_rdata <= 8'h02;
                end else begin
                    core_rdata <= sr_end;
                end
            end else begin
                core_rdata <= rxr;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_we) begin
                chk("we_re_exclusive", {31'd0, core_re}, 32'd0);
                if (wq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected none", core_addr, core_wdata);
                end else begin
                    chk("core_write", {24'd0, core_addr, core_wdata}, {16'd0, wq.pop_front()} & 32'h7FF);
                end
            end
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rsp: got err %b rdata %h expected none", rsp_err, rsp_rdata);
                end else begin
                    chk("response", {22'd0, rsp_err, rsp_rdata}, {16'd0, rq.pop_front()} & 32'h3FF);
                end
            end
        end
    end

    task automatic pw(input logic [2:0] a, input logic [7:0] d);
        wq.push_back({5'd0, a, d});
    endtask

    task automatic pr(input logic [1:0] e, input logic [7:0] d);
        rq.push_back({6'd0, e, d});
    endtask

    task automatic push_init();
        pw(3'd0, 8'h63); pw(3'd1, 8'h00); pw(3'd2, 8'h80);
    endtask

    task automatic do_req(input logic rnw, input logic [6:0] dv, input logic [7:0] rg, input logic [7:0] wd);
        int t = 0;
        @(negedge clk);
        req_rnw = rnw; req_dev = dv; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("req_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((wq.size() != 0 || rq.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", wq.size() + rq.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic init_seq();
        push_init();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("init_we", {31'd0, core_we}, 32'd1);
            chk("init_ready", {31'd0, req_ready}, (i == 2) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_rnw = 1'b0;
        req_dev = 7'h00; req_reg = 8'h00; req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {7'd0, req_ready, rsp_valid, rsp_rdata, rsp_err,
                                 core_addr, core_wdata, core_we, core_re}, 32'd0);
        init_seq();

        // Register write with three busy samples per poll.
        tip_n = 3; sr_end = 8'h00; sr_reads = 0;
        pw(3, 8'hA0); pw(4, 8'h90); pw(3, 8'h10); pw(4, 8'h10); pw(3, 8'hA5); pw(4, 8'h50);
        pr(2'b00, 8'h00);
        do_req(1'b0, 7'h50, 8'h10, 8'hA5);
        drain();
        chk("write_sr_reads", sr_reads, 32'd12);

        // Register read.
        rxr = 8'h3C; sr_reads = 0;
        pw(3, 8'hA0); pw(4, 8'h90); pw(3, 8'h20); pw(4, 8'h10); pw(3, 8'hA1); pw(4, 8'h90); pw(4, 8'h68);
        pr(2'b00, 8'h3C);
        do_req(1'b1, 7'h50, 8'h20, 8'h00);
        drain();
        chk("read_sr_reads", sr_reads, 32'd16);

        // Address NACK: STOP issued, its poll also reports NACK.
        tip_n = 0; sr_end = 8'h80; sr_reads = 0;
        pw(3, 8'hA0); pw(4, 8'h90); pw(4, 8'h40);
        pr(2'b01, 8'h00);
        do_req(1'b1, 7'h50, 8'h20, 8'h00);
        drain();
        chk("nack_sr_reads", sr_reads, 32'd2);

        // Arbitration lost (with RxACK also set): no STOP.
        tip_n = 1; sr_end = 8'hA0; sr_reads = 0;
        pw(3, 8'hA0); pw(4, 8'h90);
        pr(2'b10, 8'h00);
        do_req(1'b0, 7'h50, 8'h10, 8'h77);
        drain();
        chk("al_sr_reads", sr_reads, 32'd2);

        // TIP stuck: timeout after 2^4-1 samples, no STOP.
        tip_n = 1000; sr_end = 8'h00; sr_reads = 0;
        pw(3, 8'hA0); pw(4, 8'h90);
        pr(2'b11, 8'h00);
        do_req(1'b0, 7'h50, 8'h10, 8'h77);
        drain();
        chk("timeout_sr_reads", sr_reads, 32'd15);

        // Back-to-back writes.
        tip_n = 0; sr_end = 8'h00;
        pw(3, 8'h02); pw(4, 8'h90); pw(3, 8'h01); pw(4, 8'h10); pw(3, 8'hFF); pw(4, 8'h50);
        pr(2'b00, 8'h00);
        pw(3, 8'hFE); pw(4, 8'h90); pw(3, 8'h80); pw(4, 8'h10); pw(3, 8'h00); pw(4, 8'h50);
        pr(2'b00, 8'h00);
        do_req(1'b0, 7'h01, 8'h01, 8'hFF);
        do_req(1'b0, 7'h7F, 8'h80, 8'h00);
        drain();

        // Reset in the middle of a read: no response, init repeats.
        tip_n = 3; rxr = 8'h55;
        pw(3, 8'hA0); pw(4, 8'h90); pw(3, 8'h20); pw(4, 8'h10); pw(3, 8'hA1); pw(4, 8'h90); pw(4, 8'h68);
        pr(2'b00, 8'h55);
        do_req(1'b1, 7'h50, 8'h20, 8'h00);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        wq.delete(); rq.delete();
        #1 chk("midreset_outputs", {7'd0, req_ready, rsp_valid, rsp_rdata, rsp_err,
                                    core_addr, core_wdata, core_we, core_re}, 32'd0);
        repeat (2) @(posedge clk);
        init_seq();

        tip_n = 2; sr_end = 8'h00; rxr = 8'hC3;
        pw(3, 8'h84); pw(4, 8'h90); pw(3, 8'h05); pw(4, 8'h10); pw(3, 8'h85); pw(4, 8'h90); pw(4, 8'h68);
        pr(2'b00, 8'hC3);
        do_req(1'b1, 7'h42, 8'h05, 8'h00);
        drain();

        repeat (20) @(negedge clk);
        chk("final_queues", wq.size() + rq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
